// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the instruction/data memory arbiter.
// State encodings, access size codes and the latched request payload.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arbState_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_t;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        owner_t              owner;
        logic                wr;
        logic [SIZE_W-1:0]   size;
        logic [DATA_W-1:0]   wdata;
    } reqCtrl_t;

endpackage

// File: rtl/flopenr.sv
// Enable flop with synchronous active-low reset, used for response data registers.
module flopenr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one SRAM-like bus,
// one transaction outstanding, data access has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [SIZE_W-1:0] mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [SIZE_W-1:0] bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    arbState_t         state;
    arbState_t         stateNext;
    reqCtrl_t          ctrl;
    reqCtrl_t          grantCtrl;
    logic [ADDR_W-1:0] addrReg;
    logic [ADDR_W-1:0] grantAddr;
    logic              grant;
    logic              grantMem;
    logic              respDone;
    logic              ifEligible;
    logic              memEligible;
    logic              ifCapture;
    logic              memCapture;

    // A requester whose ready is pulsing still shows its old level request.
    assign ifEligible  = if_req & ~if_ready;
    assign memEligible = mem_req & ~mem_ready;

    always_comb begin
        stateNext = state;
        grant     = 1'b0;
        grantMem  = 1'b0;
        respDone  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (memEligible) begin
                    grant     = 1'b1;
                    grantMem  = 1'b1;
                    stateNext = ST_ADDR;
                end else if (ifEligible) begin
                    grant     = 1'b1;
                    stateNext = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    stateNext = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    stateNext = ST_IDLE;
                    respDone  = 1'b1;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Fetches are always word reads.
    always_comb begin
        grantCtrl.owner = grantMem ? OWNER_MEM : OWNER_IF;
        grantCtrl.wr    = grantMem ? mem_wr : 1'b0;
        grantCtrl.size  = grantMem ? mem_size : SIZE_WORD;
        grantCtrl.wdata = grantMem ? mem_wdata : '0;
        grantAddr       = grantMem ? mem_addr : if_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ctrl      <= '0;
            addrReg   <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            state <= stateNext;
            if (grant) begin
                ctrl    <= grantCtrl;
                addrReg <= grantAddr;
            end
            if_ready  <= respDone & (ctrl.owner == OWNER_IF);
            mem_ready <= respDone & (ctrl.owner == OWNER_MEM);
        end
    end

    assign ifCapture  = respDone & (ctrl.owner == OWNER_IF);
    assign memCapture = respDone & (ctrl.owner == OWNER_MEM) & ~ctrl.wr;

    flopenr #(.WIDTH(DATA_W)) ifRdataReg (
        .clk (clk),
        .rst (rst),
        .en  (ifCapture),
        .d   (bus_rdata),
        .q   (if_rdata)
    );

    flopenr #(.WIDTH(DATA_W)) memRdataReg (
        .clk (clk),
        .rst (rst),
        .en  (memCapture),
        .d   (bus_rdata),
        .q   (mem_rdata)
    );

    assign bus_req   = (state == ST_ADDR);
    assign bus_wr    = ctrl.wr;
    assign bus_size  = ctrl.size;
    assign bus_addr  = addrReg;
    assign bus_wdata = ctrl.wdata;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: latency, priority, stores,
// request masking, reset abandonment and a table of mixed wait-state accesses.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [31:0]       if_rdata;
    logic              if_ready;
    logic              mem_req = 1'b0;
    logic              mem_wr = 1'b0;
    logic [1:0]        mem_size = 2'd0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_addr_ok = 1'b0;
    logic              bus_data_ok = 1'b0;
    logic [31:0]       bus_rdata = '0;
    logic              stall_if;
    logic              stall_mem;

    int          checks = 0;
    int          errors = 0;
    int          txCount = 0;
    int          txStart;
    logic        monOn = 1'b0;
    logic [31:0] expIf = '0;
    logic [31:0] expMem = '0;

    typedef struct {
        logic        isMem;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          aw;
        int          dw;
    } vec_t;

    vec_t vecs [6];

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ready    (if_ready),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stall outputs follow the live request level minus the ready pulse.
    always @(negedge clk) begin
        if (monOn) begin
            checkVal("stall_if", 32'(stall_if), 32'(if_req & ~if_ready));
            checkVal("stall_mem", 32'(stall_mem), 32'(mem_req & ~mem_ready));
        end
    end

    always @(posedge clk) begin
        if (rst && bus_req && bus_addr_ok) txCount <= txCount + 1;
    end

    task automatic doTxn(input string tag, input logic isMem, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                         input int aw, input int dw);
        if (isMem) begin
            mem_req = 1'b1; mem_wr = wr; mem_size = size; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick;
        checkVal({tag, ".bus_req"}, 32'(bus_req), 32'(1));
        checkVal({tag, ".bus_addr"}, bus_addr, addr);
        checkVal({tag, ".bus_wr"}, 32'(bus_wr), 32'(isMem ? wr : 1'b0));
        checkVal({tag, ".bus_size"}, 32'(bus_size), 32'(isMem ? size : SIZE_WORD));
        if (isMem && wr) checkVal({tag, ".bus_wdata"}, bus_wdata, wdata);
        for (int i = 0; i < aw; i++) begin
            tick;
            checkVal({tag, ".hold_req"}, 32'(bus_req), 32'(1));
            checkVal({tag, ".hold_addr"}, bus_addr, addr);
        end
        bus_addr_ok = 1'b1;
        tick;
        bus_addr_ok = 1'b0;
        checkVal({tag, ".data_phase_req"}, 32'(bus_req), 32'(0));
        repeat (dw) tick;
        bus_data_ok = 1'b1;
        bus_rdata = rd;
        tick;
        bus_data_ok = 1'b0;
        bus_rdata = ~rd;
        if (isMem) begin
            if (!wr) expMem = rd;
            checkVal({tag, ".mem_ready"}, 32'(mem_ready), 32'(1));
            checkVal({tag, ".if_ready_quiet"}, 32'(if_ready), 32'(0));
            checkVal({tag, ".mem_rdata"}, mem_rdata, expMem);
            mem_req = 1'b0; mem_wr = 1'b0;
        end else begin
            expIf = rd;
            checkVal({tag, ".if_ready"}, 32'(if_ready), 32'(1));
            checkVal({tag, ".mem_ready_quiet"}, 32'(mem_ready), 32'(0));
            checkVal({tag, ".if_rdata"}, if_rdata, expIf);
            if_req = 1'b0;
        end
        tick;
        checkVal({tag, ".ready_cleared"}, 32'({if_ready, mem_ready}), 32'(0));
        checkVal({tag, ".idle_req"}, 32'(bus_req), 32'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, SIZE_WORD, 32'hBFC00010, 32'h0, 32'h8C080000, 2, 3};
        vecs[1] = '{1'b1, 1'b0, SIZE_HALF, 32'h80000102, 32'h0, 32'h0000BEEF, 5, 0};
        vecs[2] = '{1'b1, 1'b1, SIZE_WORD, 32'h80000200, 32'h12345678, 32'hFFFFFFFF, 1, 5};
        vecs[3] = '{1'b1, 1'b0, SIZE_BYTE, 32'h80000007, 32'h0, 32'h000000A5, 0, 1};
        vecs[4] = '{1'b0, 1'b0, SIZE_WORD, 32'hBFC00014, 32'h0, 32'h00000000, 4, 4};
        vecs[5] = '{1'b1, 1'b1, SIZE_HALF, 32'h80000010, 32'h0000CAFE, 32'h11111111, 3, 2};

        // Reset state
        repeat (3) tick;
        checkVal("rst.bus_req", 32'(bus_req), 32'(0));
        checkVal("rst.ready", 32'({if_ready, mem_ready}), 32'(0));
        checkVal("rst.if_rdata", if_rdata, 32'h0);
        checkVal("rst.mem_rdata", mem_rdata, 32'h0);
        checkVal("rst.bus_addr", bus_addr, 32'h0);
        checkVal("rst.bus_fields", 32'({bus_wr, bus_size}), 32'(0));
        checkVal("rst.bus_wdata", bus_wdata, 32'h0);
        rst = 1'b1;
        monOn = 1'b1;
        tick;

        // Single zero-wait fetch: bus_req at cycle 1, ready at cycle 3
        txStart = txCount;
        doTxn("fetch0", 1'b0, 1'b0, SIZE_WORD, 32'hBFC00000, 32'h0, 32'h24080001, 0, 0);
        checkVal("fetch0.txns", 32'(txCount - txStart), 32'(1));

        // Simultaneous requests: data access first, fetch follows without idle gap
        txStart = txCount;
        if_req = 1'b1; if_addr = 32'hBFC00100;
        mem_req = 1'b1; mem_wr = 1'b0; mem_size = SIZE_WORD; mem_addr = 32'h80001000;
        tick;
        checkVal("prio.first_addr", bus_addr, 32'h80001000);
        checkVal("prio.first_wr", 32'(bus_wr), 32'(0));
        bus_addr_ok = 1'b1; tick; bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'h11223344; tick; bus_data_ok = 1'b0;
        expMem = 32'h11223344;
        checkVal("prio.mem_ready", 32'(mem_ready), 32'(1));
        checkVal("prio.if_not_ready", 32'(if_ready), 32'(0));
        checkVal("prio.mem_rdata", mem_rdata, expMem);
        mem_req = 1'b0;
        tick;
        checkVal("prio.second_req", 32'(bus_req), 32'(1));
        checkVal("prio.second_addr", bus_addr, 32'hBFC00100);
        checkVal("prio.second_size", 32'(bus_size), 32'(SIZE_WORD));
        bus_addr_ok = 1'b1; tick; bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'h55667788; tick; bus_data_ok = 1'b0;
        expIf = 32'h55667788;
        checkVal("prio.if_ready", 32'(if_ready), 32'(1));
        checkVal("prio.if_rdata", if_rdata, expIf);
        if_req = 1'b0;
        repeat (2) tick;
        checkVal("prio.txns", 32'(txCount - txStart), 32'(2));

        // Byte store with 3 address wait cycles; stray data_ok in ADDR is ignored
        mem_req = 1'b1; mem_wr = 1'b1; mem_size = SIZE_BYTE;
        mem_addr = 32'h80000003; mem_wdata = 32'h000000AB;
        tick;
        checkVal("store.bus_wr", 32'(bus_wr), 32'(1));
        checkVal("store.bus_size", 32'(bus_size), 32'(SIZE_BYTE));
        for (int i = 0; i < 3; i++) begin
            bus_data_ok = (i == 1);
            tick;
            checkVal("store.wait_req", 32'(bus_req), 32'(1));
            checkVal("store.wait_addr", bus_addr, 32'h80000003);
            checkVal("store.wait_wdata", bus_wdata, 32'h000000AB);
            checkVal("store.wait_ctl", 32'({bus_wr, bus_size}), 32'({1'b1, SIZE_BYTE}));
        end
        bus_data_ok = 1'b0;
        bus_addr_ok = 1'b1; tick; bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF; tick; bus_data_ok = 1'b0;
        checkVal("store.mem_ready", 32'(mem_ready), 32'(1));
        checkVal("store.rdata_kept", mem_rdata, expMem);
        mem_req = 1'b0; mem_wr = 1'b0;
        tick;

        // Back-to-back fetches with if_req held through the ready cycle
        txStart = txCount;
        if_req = 1'b1; if_addr = 32'hBFC00004;
        tick;
        checkVal("b2b.first_addr", bus_addr, 32'hBFC00004);
        bus_addr_ok = 1'b1; tick; bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'h3C1D8000; tick; bus_data_ok = 1'b0;
        checkVal("b2b.first_ready", 32'(if_ready), 32'(1));
        checkVal("b2b.first_rdata", if_rdata, 32'h3C1D8000);
        if_addr = 32'hBFC00008;
        tick;
        checkVal("b2b.no_dup_req", 32'(bus_req), 32'(0));
        checkVal("b2b.ready_single", 32'(if_ready), 32'(0));
        tick;
        checkVal("b2b.second_req", 32'(bus_req), 32'(1));
        checkVal("b2b.second_addr", bus_addr, 32'hBFC00008);
        bus_addr_ok = 1'b1; tick; bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'h27BDFFE0; tick; bus_data_ok = 1'b0;
        expIf = 32'h27BDFFE0;
        checkVal("b2b.second_ready", 32'(if_ready), 32'(1));
        checkVal("b2b.second_rdata", if_rdata, expIf);
        if_req = 1'b0;
        tick;
        checkVal("b2b.txns", 32'(txCount - txStart), 32'(2));

        // Reset during DATA abandons the load; late data_ok is ignored
        mem_req = 1'b1; mem_wr = 1'b0; mem_size = SIZE_WORD; mem_addr = 32'h80002000;
        tick;
        bus_addr_ok = 1'b1; tick; bus_addr_ok = 1'b0;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        mem_req = 1'b0;
        expIf = 32'h0;
        expMem = 32'h0;
        checkVal("rstdata.bus_req", 32'(bus_req), 32'(0));
        checkVal("rstdata.mem_rdata", mem_rdata, expMem);
        checkVal("rstdata.if_rdata", if_rdata, expIf);
        checkVal("rstdata.bus_addr", bus_addr, 32'h0);
        tick;
        tick;
        bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick;
        bus_data_ok = 1'b0;
        checkVal("rstdata.late_bus_req", 32'(bus_req), 32'(0));
        tick;
        checkVal("rstdata.no_ready", 32'({if_ready, mem_ready}), 32'(0));
        checkVal("rstdata.mem_rdata_kept", mem_rdata, 32'h0);
        checkVal("rstdata.if_rdata_kept", if_rdata, 32'h0);

        // Mixed accesses with address/data wait states
        for (int i = 0; i < 6; i++) begin
            doTxn($sformatf("vec%0d", i), vecs[i].isMem, vecs[i].wr, vecs[i].size, vecs[i].addr,
                  vecs[i].wdata, vecs[i].rd, vecs[i].aw, vecs[i].dw);
        end
        checkVal("final.mem_rdata", mem_rdata, 32'h000000A5);
        checkVal("final.if_rdata", if_rdata, 32'h00000000);

        monOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
